if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Parametrised instruction queue between the AXI fetch stage and ID. It replaces the single-entry stall buffer with a DEPTH-entry FIFO of {pc, inst} pairs.
- Decouples AXI fetch latency from ID stalls and tracks the branch delay-slot tag per issued instruction.
- Outputs a zero PC/instruction bubble when empty, in reset, or while ID is stalled.
- Drives the fetch-permission signal to the AXI front end.

Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, at least 2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush  in  1  exception/flush; empties the queue
- stall_id  in  1  stall[1]; high means ID holds its current instruction
- in_valid  in  1  fetch delivers in_pc/in_inst this cycle
- in_pc  in  ADDR_W  fetched PC
- in_inst  in  INST_W  fetched instruction
- in_ready  out  1  queue may accept a push; AXI may issue the next PC
- id_next_in_delay_slot  in  1  from ID: the instruction issued next is a delay slot
- id_valid  out  1  id_pc/id_inst carry a real instruction
- id_pc  out  ADDR_W  head PC, else 0
- id_inst  out  INST_W  head instruction, else 0
- id_in_delay_slot  out  1  issued instruction is a delay slot
- count  out  CNT_W  current occupancy

Behaviour:
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
  - full: count == DEPTH. empty: count == 0.
- push = in_valid && in_ready && !flush.
- pop = id_valid && !stall_id.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- in_ready = !full && !rst && !flush. It is computed from registered state plus rst/flush only, with no path from stall_id.
- in_valid while !in_ready: the data is dropped. This is a protocol error; the bench asserts it never happens when not flushing.
- Output and latency:
  - id_valid = !empty && !stall_id && !rst.
  - id_pc/id_inst = head entry when id_valid, else 0; head is combinational from storage.
  - Minimum latency from push to ID visibility is 1 cycle; there is no same-cycle bypass.
- Delay-slot tracking uses register ds_pending.
  - rst or flush: ds_pending <= 0.
  - Else if id_next_in_delay_slot: ds_pending <= 1. The flag is held across empty and stall cycles.
  - Else if pop: ds_pending <= 0.
  - id_in_delay_slot = ds_pending && id_valid, so the tag is consumed by exactly one issued instruction.
- Flush: in the same clock edge, count, wr_ptr, rd_ptr and ds_pending are cleared. Any push that cycle is discarded. id_* outputs are unaffected in the flush cycle itself.
- Restart after reset:
  - A registered one-cycle restart pulse is ORed into in_ready so the front end issues its first fetch.
  - It fires on the first cycle after rst falls; it is masked if flush is high.
- Reset (rst high at a clock edge):
  - count=0, pointers=0, ds_pending=0.
  - id_valid=0, id_pc=0, id_inst=0, id_in_delay_slot=0, in_ready=0.
  - Reset mid-stream discards every entry.
- Storage array contents are not reset; they are only read when non-empty.
- count never exceeds DEPTH and never underflows; pop on empty is impossible by construction.

Decomposition:
- Shared package/defines: ZeroWord, RstEnable, Stop/NoStop, Valid/InValid, plus InstAddrBus/InstBus widths as defaults for ADDR_W/INST_W.
- One natural sub-module, if_id_queue_ram: a DEPTH x (ADDR_W+INST_W) register-file with one write port and an asynchronous read port.
- Pointer, count, delay-slot and restart logic stay in the top module.

Test Plan:
1. Reset release, DEPTH=4, no fetch. Required: outputs 0 and in_ready=0 during rst; in_ready=1 on the first cycle after rst falls (restart pulse); count=0.
2. Push pc 0xBFC00000/0x00000001, then 0xBFC00004/0x00000002, stall_id=0. Required: id_pc=0xBFC00000 the cycle after the first push, then 0xBFC00004; count returns to 0.
3. stall_id=1 held while 4 pushes occur. Required: id_valid=0 and id_pc=0 throughout; count reaches 4; in_ready=0. After stall drops, the 4 entries pop in order, one per cycle, and in_ready rises the cycle after the first pop.
4. Full queue with simultaneous push and pop. Required: count stays at DEPTH-1/DEPTH as expected; wr_ptr wraps from 3 to 0; FIFO order is preserved across the wrap.
5. id_next_in_delay_slot=1 on a cycle where the queue is empty, then one push. Required: id_in_delay_slot=1 only with that next issued instruction; 0 for the one after.
6. flush asserted with 3 entries queued and in_valid=1. Required: count=0 next cycle, the pushed entry is discarded, ds_pending is cleared, and id_valid=0 until a new push.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue slice.
package if_id_queue_pkg;

  localparam int unsigned InstAddrBusW = 32;
  localparam int unsigned InstBusW     = 32;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic        Valid     = 1'b1;
  localparam logic        InValid   = 1'b0;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and ID-side signals of the IF/ID instruction queue.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrBusW,
  parameter int unsigned INST_W = InstBusW,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
);

  logic              flush;
  logic              stall_id;
  logic              in_valid;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              id_next_in_delay_slot;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_in_delay_slot;
  logic [CNT_W-1:0]  count;

  // Queue side
  modport slave (
    input  flush, stall_id, in_valid, in_pc, in_inst, id_next_in_delay_slot,
    output in_ready, id_valid, id_pc, id_inst, id_in_delay_slot, count
  );

  // Fetch/ID side
  modport master (
    output flush, stall_id, in_valid, in_pc, in_inst, id_next_in_delay_slot,
    input  in_ready, id_valid, id_pc, id_inst, id_in_delay_slot, count
  );

endinterface

// File: rtl/if_id_queue_ram.sv
// DEPTH-entry register file: one synchronous write port, one asynchronous read port.
module if_id_queue_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; they are only read while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of {pc, inst} with delay-slot tagging.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrBusW,
  parameter int unsigned INST_W = InstBusW,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ds_pending;
  logic             restart_q;
  logic             in_rst;
  logic             full;
  logic             empty;
  logic             restart;
  logic             ready_c;
  logic             valid_c;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign in_rst  = (rst == RstEnable);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  // One-cycle pulse on the first cycle after reset deasserts
  assign restart = restart_q && !in_rst;
  assign ready_c = ((!full && !in_rst) || restart) && !bus.flush;
  assign valid_c = !empty && (bus.stall_id == NoStop) && !in_rst;
  assign push    = bus.in_valid && ready_c && !bus.flush;
  assign pop     = valid_c;

  if_id_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({bus.in_pc, bus.in_inst}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.in_ready         = ready_c;
  assign bus.id_valid         = valid_c ? Valid : InValid;
  assign bus.id_pc            = valid_c ? head[ENT_W-1:INST_W] : ADDR_W'(ZeroWord);
  assign bus.id_inst          = valid_c ? head[INST_W-1:0]     : INST_W'(ZeroWord);
  assign bus.id_in_delay_slot = ds_pending && valid_c;
  assign bus.count            = cnt;

  always_ff @(posedge clk) begin
    restart_q <= in_rst;
  end

  // Pointer, occupancy and delay-slot state; flush behaves like reset for the queue
  always_ff @(posedge clk) begin
    if (in_rst || bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      ds_pending <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (bus.id_next_in_delay_slot) begin
        ds_pending <= 1'b1;
      end else if (pop) begin
        ds_pending <= 1'b0;
      end
    end
  end

endmodule
